dma_channel_arbiter: RTL and testbench

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

---
 rtl/dma_channel_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_channel_arbiter
// Description : Four-channel round-robin front end for a single DMA_READ
//               engine. It grants one requesting channel at a time, latches
//               that channel's descriptor (source, destination, length) and
//               starts the engine. It then waits for the engine to finish and
//               reports completion, or an error, back to the channel.
//               A zero-length descriptor is rejected without starting the
//               engine. A transfer that sees no engine completion within
//               TIMEOUT cycles is abandoned and the engine is flushed.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT    WAIT cycles without done before the transfer is abandoned
//              (2..65535)
// Ports
//   clk        in   1    single clock, rising edge
//   rst        in   1    synchronous active-high reset
//   ch_req     in   4    per-channel request level, held until ch_ack
//   ch_src     in   128  channel n source address at [32n+31:32n]
//   ch_dest    in   128  channel n destination address at [32n+31:32n]
//   ch_len     in   24   channel n byte length at [6n+5:6n]
//   ch_ack     out  4    one-cycle descriptor-captured pulse
//   ch_done    out  4    one-cycle completion pulse
//   ch_err     out  4    one-cycle error pulse, coincident with ch_done
//   trigger    out  1    one-cycle engine start pulse
//   length     out  6    latched byte length to the engine
//   src_addr   out  32   latched source address to the engine
//   dest_addr  out  32   latched destination address to the engine
//   done       in   1    engine completion, only honoured in WAIT
//   eng_flush  out  1    one-cycle engine flush pulse on timeout
//   busy       out  1    high whenever a transfer is in progress
//   active_ch  out  2    current or most recent granted channel
// ============================================================================
module dma_channel_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   ch_req,
    input  logic [127:0] ch_src,
    input  logic [127:0] ch_dest,
    input  logic [23:0]  ch_len,
    output logic [3:0]   ch_ack,
    output logic [3:0]   ch_done,
    output logic [3:0]   ch_err,
    output logic         trigger,
    output logic [5:0]   length,
    output logic [31:0]  src_addr,
    output logic [31:0]  dest_addr,
    input  logic         done,
    output logic         eng_flush,
    output logic         busy,
    output logic [1:0]   active_ch
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] C_ST_IDLE     = 3'd0;
    localparam logic [2:0] C_ST_LAUNCH   = 3'd1;
    localparam logic [2:0] C_ST_WAIT     = 3'd2;
    localparam logic [2:0] C_ST_COMPLETE = 3'd3;
    localparam logic [2:0] C_ST_REJECT   = 3'd4;
    localparam logic [2:0] C_ST_TMO      = 3'd5;

    // Counter value on the last WAIT cycle before the transfer is abandoned
    localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [2:0]  state_q,      state_d;
    logic [15:0] cnt_q,        cnt_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  active_ch_q,  active_ch_d;
    logic [5:0]  length_q,     length_d;
    logic [31:0] src_addr_q,   src_addr_d;
    logic [31:0] dest_addr_q,  dest_addr_d;
    logic [3:0]  ch_ack_q,     ch_ack_d;
    logic [3:0]  ch_done_q,    ch_done_d;
    logic [3:0]  ch_err_q,     ch_err_d;
    logic        trigger_q,    trigger_d;
    logic        eng_flush_q,  eng_flush_d;
    logic        busy_q,       busy_d;

    // ------------------------------------------------------------------
    // Round-robin grant search
    // ------------------------------------------------------------------
    // Candidates are visited from last_grant+1 upward with 2-bit wrap, so
    // the channel granted last has the lowest priority next time round.
    logic       w_grant_vld;
    logic [1:0] w_grant;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            if (!w_grant_vld && ch_req[last_grant_q + 2'(k)]) begin
                w_grant_vld = 1'b1;
                w_grant     = last_grant_q + 2'(k);
            end
        end
    end

    // Descriptor fields of the winning channel
    logic [5:0]  w_sel_len;
    logic [31:0] w_sel_src;
    logic [31:0] w_sel_dest;

    always_comb begin
        w_sel_len  = ch_len[5:0];
        w_sel_src  = ch_src[31:0];
        w_sel_dest = ch_dest[31:0];
        case (w_grant)
            2'd1: begin
                w_sel_len  = ch_len[11:6];
                w_sel_src  = ch_src[63:32];
                w_sel_dest = ch_dest[63:32];
            end
            2'd2: begin
                w_sel_len  = ch_len[17:12];
                w_sel_src  = ch_src[95:64];
                w_sel_dest = ch_dest[95:64];
            end
            2'd3: begin
                w_sel_len  = ch_len[23:18];
                w_sel_src  = ch_src[127:96];
                w_sel_dest = ch_dest[127:96];
            end
            default: begin
                w_sel_len  = ch_len[5:0];
                w_sel_src  = ch_src[31:0];
                w_sel_dest = ch_dest[31:0];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= C_ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 2'd3;
            active_ch_q  <= '0;
            length_q     <= '0;
            src_addr_q   <= '0;
            dest_addr_q  <= '0;
            ch_ack_q     <= '0;
            ch_done_q    <= '0;
            ch_err_q     <= '0;
            trigger_q    <= 1'b0;
            eng_flush_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            active_ch_q  <= active_ch_d;
            length_q     <= length_d;
            src_addr_q   <= src_addr_d;
            dest_addr_q  <= dest_addr_d;
            ch_ack_q     <= ch_ack_d;
            ch_done_q    <= ch_done_d;
            ch_err_q     <= ch_err_d;
            trigger_q    <= trigger_d;
            eng_flush_q  <= eng_flush_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        active_ch_d  = active_ch_q;
        length_d     = length_q;
        src_addr_d   = src_addr_q;
        dest_addr_d  = dest_addr_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_grant_vld) begin
                    last_grant_d = w_grant;
                    active_ch_d  = w_grant;
                    length_d     = w_sel_len;
                    src_addr_d   = w_sel_src;
                    dest_addr_d  = w_sel_dest;
                    state_d      = (w_sel_len != 6'd0) ? C_ST_LAUNCH : C_ST_REJECT;
                end
            end
            C_ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = C_ST_WAIT;
            end
            C_ST_WAIT: begin
                // A completion on the final WAIT cycle takes priority over
                // the timeout.
                if (done) begin
                    state_d = C_ST_COMPLETE;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = C_ST_TMO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            C_ST_COMPLETE,
            C_ST_REJECT,
            C_ST_TMO: begin
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // Outputs are registered: their next values are decoded from the state
    // being entered, so each pulse lines up with that state's cycle.
    logic [3:0] w_grant_onehot;

    always_comb begin
        w_grant_onehot = 4'b0001 << active_ch_d;
        ch_ack_d       = '0;
        ch_done_d      = '0;
        ch_err_d       = '0;
        trigger_d      = 1'b0;
        eng_flush_d    = 1'b0;
        busy_d         = (state_d != C_ST_IDLE);
        case (state_d)
            C_ST_LAUNCH: begin
                trigger_d = 1'b1;
                ch_ack_d  = w_grant_onehot;
            end
            C_ST_COMPLETE: begin
                ch_done_d = w_grant_onehot;
            end
            C_ST_REJECT: begin
                ch_ack_d  = w_grant_onehot;
                ch_done_d = w_grant_onehot;
                ch_err_d  = w_grant_onehot;
            end
            C_ST_TMO: begin
                ch_done_d   = w_grant_onehot;
                ch_err_d    = w_grant_onehot;
                eng_flush_d = 1'b1;
            end
            default: begin
                ch_ack_d = '0;
            end
        endcase
    end

    assign ch_ack    = ch_ack_q;
    assign ch_done   = ch_done_q;
    assign ch_err    = ch_err_q;
    assign trigger   = trigger_q;
    assign length    = length_q;
    assign src_addr  = src_addr_q;
    assign dest_addr = dest_addr_q;
    assign eng_flush = eng_flush_q;
    assign busy      = busy_q;
    assign active_ch = active_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_channel_arbiter
// Description : Directed bench for dma_channel_arbiter with TIMEOUT = 8.
//               A transaction-level reference thread predicts every output
//               each cycle; a compare process checks them on the falling
//               edge. Hand-computed literal checks pin key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_channel_arbiter;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   ch_req = '0;
    logic [127:0] ch_src = '0;
    logic [127:0] ch_dest = '0;
    logic [23:0]  ch_len = '0;
    logic         done = 1'b0;
    logic [3:0]   ch_ack, ch_done, ch_err;
    logic         trigger, eng_flush, busy;
    logic [5:0]   length;
    logic [31:0]  src_addr, dest_addr;
    logic [1:0]   active_ch;

    dma_channel_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_req    (ch_req),
        .ch_src    (ch_src),
        .ch_dest   (ch_dest),
        .ch_len    (ch_len),
        .ch_ack    (ch_ack),
        .ch_done   (ch_done),
        .ch_err    (ch_err),
        .trigger   (trigger),
        .length    (length),
        .src_addr  (src_addr),
        .dest_addr (dest_addr),
        .done      (done),
        .eng_flush (eng_flush),
        .busy      (busy),
        .active_ch (active_ch)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one thread walks through each transaction
    // ------------------------------------------------------------------
    logic [3:0]  e_ack = '0, e_done = '0, e_err = '0;
    logic        e_trig = 1'b0, e_flush = 1'b0, e_busy = 1'b0;
    logic [5:0]  e_len = '0;
    logic [31:0] e_src = '0, e_dst = '0;
    logic [1:0]  e_act = '0;
    int          m_lg = 3;

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Advance one clock edge; pulses last one cycle, reset clears everything.
    task automatic m_step(output bit aborted);
        @(posedge clk);
        e_ack = '0; e_done = '0; e_err = '0; e_trig = 1'b0; e_flush = 1'b0;
        aborted = rst;
        if (rst) begin
            e_busy = 1'b0; e_len = '0; e_src = '0; e_dst = '0; e_act = '0;
            m_lg = 3;
        end
    endtask

    initial begin : model
        bit ab;
        int g;
        int waited;
        forever begin
            m_step(ab);
            if (ab || ch_req == 4'b0) begin
                e_busy = 1'b0;
                continue;
            end
            g      = rr_pick(ch_req, m_lg);
            m_lg   = g;
            e_act  = 2'(g);
            e_len  = ch_len[6*g +: 6];
            e_src  = ch_src[32*g +: 32];
            e_dst  = ch_dest[32*g +: 32];
            e_busy = 1'b1;
            e_ack  = 4'(1 << g);
            if (e_len == 6'd0) begin
                e_done = 4'(1 << g);
                e_err  = 4'(1 << g);
                m_step(ab);
                e_busy = 1'b0;
                continue;
            end
            e_trig = 1'b1;
            m_step(ab);
            if (ab) continue;
            waited = 0;
            forever begin
                m_step(ab);
                if (ab) break;
                if (done) begin
                    e_done = 4'(1 << g);
                    break;
                end
                waited++;
                if (waited == TMO) begin
                    e_done  = 4'(1 << g);
                    e_err   = 4'(1 << g);
                    e_flush = 1'b1;
                    break;
                end
            end
            if (ab) continue;
            m_step(ab);
            e_busy = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("ch_ack",    ch_ack,    e_ack);
            chk("ch_done",   ch_done,   e_done);
            chk("ch_err",    ch_err,    e_err);
            chk("trigger",   trigger,   e_trig);
            chk("eng_flush", eng_flush, e_flush);
            chk("busy",      busy,      e_busy);
            chk("length",    length,    e_len);
            chk("src_addr",  src_addr,  e_src);
            chk("dest_addr", dest_addr, e_dst);
            chk("active_ch", active_ch, e_act);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [5:0] l);
        ch_src[32*ch +: 32]  = s;
        ch_dest[32*ch +: 32] = d;
        ch_len[6*ch +: 6]    = l;
    endtask

    task automatic wait_trigger();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            if (trigger === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("trigger_wait_timeout", 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stim
        int exp_g[5];
        int n;
        exp_g = '{0, 1, 2, 3, 0};

        // Reset state
        rst = 1'b1;
        tick();
        check_en = 1'b1;
        chk("rst_busy",      busy,      64'd0);
        chk("rst_active_ch", active_ch, 64'd0);
        chk("rst_src_addr",  src_addr,  64'd0);
        tick();
        rst = 1'b0;

        // Single transfer on ch0; a stray done in IDLE is ignored first
        set_desc(0, 32'h0000_000A, 32'h0000_0100, 6'd4);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idle_done_ignored", busy, 64'd0);
        ch_req = 4'b0001;
        tick();
        chk("t1_trigger",  trigger,  64'd1);
        chk("t1_ack",      ch_ack,   64'h1);
        chk("t1_src_addr", src_addr, 64'h0A);
        chk("t1_length",   length,   64'd4);
        ch_req = 4'b0000;
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t1_done", ch_done, 64'h1);
        chk("t1_err",  ch_err,  64'h0);
        tick();
        chk("t1_idle_busy", busy, 64'd0);

        // Round-robin with all four channels requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_desc(1, 32'h1111_0000, 32'h2222_0000, 6'd8);
        set_desc(2, 32'h3333_0000, 32'h4444_0000, 6'd16);
        set_desc(3, 32'h5555_0000, 32'h6666_0000, 6'd63);
        ch_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_trigger();
            chk("rr_grant", active_ch, 64'(exp_g[i]));
            tick();
            tick();
            done = 1'b1;
            if (i == 4) ch_req = 4'b0000;
            tick();
            done = 1'b0;
        end
        tick();

        // Zero-length descriptor on ch2 is rejected
        set_desc(2, 32'h3333_0000, 32'h4444_0000, 6'd0);
        ch_req = 4'b0100;
        tick();
        chk("rej_ack",     ch_ack,  64'h4);
        chk("rej_done",    ch_done, 64'h4);
        chk("rej_err",     ch_err,  64'h4);
        chk("rej_trigger", trigger, 64'd0);
        ch_req = 4'b0000;
        tick();
        chk("rej_idle_busy", busy, 64'd0);

        // Timeout on ch1: engine never answers
        ch_req = 4'b0010;
        tick();
        chk("tmo_trigger", trigger, 64'd1);
        ch_req = 4'b0000;
        n = 0;
        for (int k = 0; k < 20 && eng_flush !== 1'b1; k++) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'd9);
        chk("tmo_done",   ch_done, 64'h2);
        chk("tmo_err",    ch_err,  64'h2);
        tick();
        chk("tmo_busy_drop", busy, 64'd0);

        // done on the final WAIT cycle wins over the timeout
        ch_req = 4'b0001;
        tick();
        ch_req = 4'b0000;
        repeat (TMO) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("last_done",  ch_done,   64'h1);
        chk("last_err",   ch_err,    64'h0);
        chk("last_flush", eng_flush, 64'd0);
        tick();

        // Reset during WAIT aborts silently; ch3 granted afterwards
        set_desc(2, 32'h3333_0000, 32'h4444_0000, 6'd3);
        ch_req = 4'b0100;
        tick();
        chk("rst_case_grant", active_ch, 64'd2);
        ch_req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",   busy,      64'd0);
        chk("abort_done",   ch_done,   64'h0);
        chk("abort_err",    ch_err,    64'h0);
        chk("abort_flush",  eng_flush, 64'd0);
        chk("abort_length", length,    64'd0);
        chk("abort_active", active_ch, 64'd0);
        ch_req = 4'b1000;
        tick();
        chk("post_rst_grant", active_ch, 64'd3);
        chk("post_rst_ack",   ch_ack,    64'h8);
        ch_req = 4'b0000;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("post_rst_done", ch_done, 64'h8);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
